nco_freq_scheduler: RTL and testbench
=====================================

// Module: nco_freq_scheduler
// PURPOSE
//  Sequences the nco frequency word through a programmable table of steps. Each step holds
//  one 32-bit num for a set number of clk_gen rising edges, then advances.
//  Sits between the control/register logic and nco; its num output drives nco.num directly.
//  Supports one-shot or looping sweeps, software stop, and a done pulse.
// PARAMETERS
//  DEPTH   8    number of table entries (power of 2, >=2)
//  AW      3    table address width, $clog2(DEPTH)
//  CW      16   hold-count width (clk_gen edges per step)
// PORTS
//  clk       in   1    system clock, 50 MHz
//  rst       in   1    synchronous, active-high reset
//  wr_en     in   1    table write strobe
//  wr_addr   in   AW   table entry to write
//  wr_num    in   32   frequency word for entry
//  wr_hold   in   CW   hold count for entry (0 treated as 1)
//  start     in   1    begin sweep at entry 0 (ignored while busy)
//  stop      in   1    abort sweep, return to IDLE
//  loop_en   in   1    1: wrap to entry 0 after last_idx; 0: finish
//  last_idx  in   AW   final entry of the sweep (sampled every step end)
//  nco_tick  in   1    clk_gen fed back from nco
//  num       out  32   frequency word to nco
//  idx       out  AW   entry currently active
//  busy      out  1    high in LOAD/RUN
//  done      out  1    one-cycle pulse at end of a non-looping sweep
// BEHAVIOUR
//  Reset: state=IDLE, num=0, idx=0, busy=0, done=0, hold_cnt=0, tick_d=0. Table contents are
//   not reset.
//  Table: DEPTH x {num[31:0], hold[CW-1:0]}. Writes are accepted in any state.
//   A write and a read of the same entry in the same cycle: the read returns the old data.
//  Edge detect: tick_d <= nco_tick each cycle. rise = nco_tick & ~tick_d.
//   nco_tick is clk-synchronous, so no synchroniser is used.
//  FSM states: IDLE, LOAD, RUN, DONE.
//   IDLE: num=0, busy=0. start & ~stop -> LOAD with idx=0.
//   LOAD (1 cycle): num <= tbl[idx].num; hold_cnt <= max(tbl[idx].hold,1); -> RUN.
//   RUN: on rise, hold_cnt decrements. A rise with hold_cnt==1 ends the step:
//     idx!=last_idx        -> idx+1, LOAD
//     idx==last_idx & loop -> idx=0, LOAD
//     idx==last_idx & ~loop-> DONE
//    If idx reaches DEPTH-1 with last_idx greater, it wraps to 0.
//   DONE (1 cycle): done=1, num=0, idx=0 -> IDLE.
//  Latency: start at cycle T -> LOAD at T+1 -> num valid at T+2.
//   Step end (rise at T) -> new num at T+2.
//  num is held stable across LOAD for continuing steps. It changes only on the LOAD->RUN edge.
//  Priority: rst > stop > step end > start. stop in any state -> IDLE next cycle,
//   num=0, idx=0, and no done pulse.
//  start while busy is ignored. start and stop in the same cycle resolve as stop.
//  num is 32-bit unsigned and passed through unmodified. hold_cnt does not underflow
//   (floor 1).
// STRUCTURE
//  nco_sched_pkg: state_t enum {IDLE,LOAD,RUN,DONE}; entry_t struct {num[31:0],hold[CW-1:0]};
//   and the constant HOLD_MIN=1.
//  Sub-module nco_sched_tbl: DEPTH-entry register file with 1 write port and
//   1 async read port.
//  The FSM, counter and edge detect stay in the top level.
// TESTING
//  1 Reset: rst=1 for 10 clk, then release.
//    -> num=0, idx=0, busy=0, done=0; no change with nco_tick toggling.
//  2 Single sweep: tbl0={50000000,3}, tbl1={25000000,2}, last_idx=1, loop_en=0, start.
//    -> num=50000000 two cycles after start, held for 3 rises.
//    -> then num=25000000 for 2 rises.
//    -> done pulses once; num=0, busy=0.
//  3 Loop: same table, loop_en=1.
//    -> idx sequence 0,1,0,1...; no done.
//    -> stop mid-step gives num=0 and idx=0 next cycle, no done.
//  4 Zero hold: tbl0.hold=0, last_idx=0, loop_en=0.
//    -> step lasts exactly 1 rise, then done.
//  5 Collisions:
//    start+stop same cycle -> stays IDLE.
//    start during RUN -> ignored.
//    wr_en to tbl[idx+1] in the cycle the step ends -> LOAD picks up the old value.
//  6 Mid-op reset: rst=1 during RUN with hold_cnt=2
//    -> all outputs at reset values next cycle.
//    -> a subsequent start runs a sweep from entry 0.

Source files
------------

// File: rtl/nco_sched_pkg.sv
// Shared types and constants for the NCO frequency scheduler.
package nco_sched_pkg;

    localparam int unsigned NUM_W    = 32;
    localparam int unsigned HOLD_W   = 16;
    localparam int unsigned HOLD_MIN = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [NUM_W-1:0]  num;
        logic [HOLD_W-1:0] hold;
    } entry_t;

endpackage

// File: rtl/nco_sched_tbl.sv
// Step table: DEPTH entries, one synchronous write port, one asynchronous read port.
// A same-cycle write and read of one entry returns the old contents.
module nco_sched_tbl
    import nco_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  entry_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output entry_t        rd_data
);

    entry_t mem [DEPTH];

    // Table write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nco_freq_scheduler.sv
// Steps the NCO frequency word through a programmable table, holding each
// entry for a programmed number of clk_gen rising edges.
module nco_freq_scheduler
    import nco_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned CW    = HOLD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_num,
    input  logic [CW-1:0] wr_hold,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW-1:0] last_idx,
    input  logic          nco_tick,
    output logic [31:0]   num,
    output logic [AW-1:0] idx,
    output logic          busy,
    output logic          done
);

    state_t        state, state_nxt;
    logic [31:0]   num_nxt;
    logic [AW-1:0] idx_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic          tick_d;
    logic          rise;
    logic          enter_load;
    entry_t        wr_entry;
    entry_t        rd_entry;
    entry_t        ld_entry;

    assign wr_entry = '{num: wr_num, hold: HOLD_W'(wr_hold)};
    assign rise     = nco_tick & ~tick_d;
    assign busy     = (state == LOAD) || (state == RUN);
    assign done     = (state == DONE);

    // The table is read at the address being entered, in the cycle the FSM
    // decides to load, so a write landing in that same cycle is not seen.
    nco_sched_tbl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tbl (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_entry),
        .rd_addr (idx_nxt),
        .rd_data (rd_entry)
    );

    // State, datapath registers, tick edge detector and captured table entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            num      <= '0;
            idx      <= '0;
            hold_cnt <= '0;
            tick_d   <= 1'b0;
            ld_entry <= '0;
        end else begin
            state    <= state_nxt;
            num      <= num_nxt;
            idx      <= idx_nxt;
            hold_cnt <= hold_nxt;
            tick_d   <= nco_tick;
            if (enter_load) begin
                ld_entry <= rd_entry;
            end
        end
    end

    // Next-state and datapath update; stop overrides step end, which overrides start.
    always_comb begin
        state_nxt  = state;
        num_nxt    = num;
        idx_nxt    = idx;
        hold_nxt   = hold_cnt;
        enter_load = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
            num_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    num_nxt = '0;
                    if (start) begin
                        state_nxt  = LOAD;
                        idx_nxt    = '0;
                        enter_load = 1'b1;
                    end
                end
                LOAD: begin
                    num_nxt   = ld_entry.num;
                    hold_nxt  = (ld_entry.hold == '0) ? CW'(HOLD_MIN) : CW'(ld_entry.hold);
                    state_nxt = RUN;
                end
                RUN: begin
                    if (rise) begin
                        if (hold_cnt > CW'(HOLD_MIN)) begin
                            hold_nxt = hold_cnt - CW'(1);
                        end else if (idx != last_idx) begin
                            idx_nxt    = idx + AW'(1);
                            state_nxt  = LOAD;
                            enter_load = 1'b1;
                        end else if (loop_en) begin
                            idx_nxt    = '0;
                            state_nxt  = LOAD;
                            enter_load = 1'b1;
                        end else begin
                            state_nxt = DONE;
                            num_nxt   = '0;
                            idx_nxt   = '0;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    num_nxt   = '0;
                    idx_nxt   = '0;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_freq_scheduler.sv
// Scoreboard bench for nco_freq_scheduler: stimulus queues the expected output
// changes with their cycle stamps; a monitor compares every observed change.
module tb_nco_freq_scheduler;
    import nco_sched_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = 16;
    localparam logic [31:0] F50   = 32'd50000000;
    localparam logic [31:0] F25   = 32'd25000000;

    logic          clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0;
    logic          loop_en = 1'b0, nco_tick = 1'b0;
    logic [AW-1:0] wr_addr = '0, last_idx = '0;
    logic [31:0]   wr_num = '0;
    logic [CW-1:0] wr_hold = '0;
    logic [31:0]   num;
    logic [AW-1:0] idx;
    logic          busy, done;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;

    typedef struct {
        int unsigned   cyc;
        logic [31:0]   num;
        logic [AW-1:0] idx;
        logic          busy;
        logic          done;
    } ev_t;
    ev_t evq[$];

    nco_freq_scheduler #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_num   (wr_num),
        .wr_hold  (wr_hold),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .last_idx (last_idx),
        .nco_tick (nco_tick),
        .num      (num),
        .idx      (idx),
        .busy     (busy),
        .done     (done)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: every change of the output tuple must match the next queued event.
    logic [36:0] prev = '0;
    always @(negedge clk) begin
        logic [36:0] cur;
        ev_t e;
        cur = {num, idx, busy, done};
        if (mon_en && cur !== prev) begin
            checks++;
            if (evq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d actual num=%h idx=%0d busy=%b done=%b required no change",
                         cyc, num, idx, busy, done);
            end else begin
                e = evq.pop_front();
                if (e.cyc != cyc || e.num !== num || e.idx !== idx || e.busy !== busy || e.done !== done) begin
                    failures++;
                    $display("FAIL event actual cyc=%0d num=%h idx=%0d busy=%b done=%b required cyc=%0d num=%h idx=%0d busy=%b done=%b",
                             cyc, num, idx, busy, done, e.cyc, e.num, e.idx, e.busy, e.done);
                end
            end
        end
        prev = cur;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int unsigned at, input logic [31:0] n, input logic [AW-1:0] i,
                             input logic b, input logic d);
        ev_t e;
        e.cyc = at; e.num = n; e.idx = i; e.busy = b; e.done = d;
        evq.push_back(e);
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [31:0] n, input logic [CW-1:0] h);
        wr_en = 1'b1; wr_addr = a; wr_num = n; wr_hold = h;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rise();
        nco_tick = 1'b1;
        @(negedge clk);
        nco_tick = 1'b0;
        @(negedge clk);
    endtask

    // Start a sweep: LOAD one cycle later, entry 0's word one cycle after that.
    task automatic do_start(input logic [31:0] first);
        expect_ev(cyc + 1, 32'd0, '0, 1'b1, 1'b0);
        expect_ev(cyc + 2, first, '0, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // A rise that ends a step and moves to entry i (old word held through LOAD).
    task automatic step_to(input logic [31:0] old_n, input logic [31:0] new_n, input logic [AW-1:0] i);
        expect_ev(cyc + 1, old_n, i, 1'b1, 1'b0);
        expect_ev(cyc + 2, new_n, i, 1'b1, 1'b0);
        rise();
    endtask

    // A rise that ends the final step of a one-shot sweep.
    task automatic end_done();
        expect_ev(cyc + 1, 32'd0, '0, 1'b0, 1'b1);
        expect_ev(cyc + 2, 32'd0, '0, 1'b0, 1'b0);
        rise();
    endtask

    initial begin
        // Reset, then confirm ticks alone do nothing.
        cycles(10);
        rst = 1'b0;
        cycles(1);
        check("reset_num", num, 32'd0);
        check("reset_idx", 32'(idx), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (3) rise();
        check("idle_tick_num", num, 32'd0);
        check("idle_tick_idx", 32'(idx), 32'd0);
        check("idle_tick_busy", 32'(busy), 32'd0);
        check("idle_tick_done", 32'(done), 32'd0);
        mon_en = 1'b1;

        // Single sweep over two entries.
        write_entry(3'd0, F50, 16'd3);
        write_entry(3'd1, F25, 16'd2);
        last_idx = 3'd1;
        loop_en  = 1'b0;
        do_start(F50);
        rise(); rise();
        step_to(F50, F25, 3'd1);
        rise();
        end_done();
        cycles(2);

        // Looping sweep, then stop in the middle of entry 1.
        loop_en = 1'b1;
        do_start(F50);
        rise(); rise();
        step_to(F50, F25, 3'd1);
        rise();
        step_to(F25, F50, 3'd0);
        rise(); rise();
        step_to(F50, F25, 3'd1);
        rise();
        expect_ev(cyc + 1, 32'd0, '0, 1'b0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cycles(2);

        // Zero hold behaves as a single rise.
        write_entry(3'd0, 32'hDEADBEEF, 16'd0);
        last_idx = 3'd0;
        loop_en  = 1'b0;
        do_start(32'hDEADBEEF);
        end_done();
        cycles(2);

        // start together with stop stays idle.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        cycles(3);
        check("start_stop_busy", 32'(busy), 32'd0);
        check("start_stop_num", num, 32'd0);

        // start during RUN is ignored; a write to the next entry in the
        // step-ending cycle is not seen by that LOAD.
        write_entry(3'd0, F50, 16'd3);
        last_idx = 3'd1;
        do_start(F50);
        rise();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rise();
        expect_ev(cyc + 1, F50, 3'd1, 1'b1, 1'b0);
        expect_ev(cyc + 2, F25, 3'd1, 1'b1, 1'b0);
        wr_en = 1'b1; wr_addr = 3'd1; wr_num = 32'h12345678; wr_hold = 16'd5;
        nco_tick = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; nco_tick = 1'b0;
        @(negedge clk);
        rise();
        end_done();
        cycles(2);

        // The colliding write did land for the next sweep.
        do_start(F50);
        rise(); rise();
        step_to(F50, 32'h12345678, 3'd1);
        repeat (4) rise();
        end_done();
        cycles(2);

        // Reset during RUN with two rises left, then a fresh sweep.
        last_idx = 3'd0;
        do_start(F50);
        rise();
        expect_ev(cyc + 1, 32'd0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_num", num, 32'd0);
        check("midrst_idx", 32'(idx), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        cycles(1);
        do_start(F50);
        rise(); rise();
        end_done();
        cycles(3);

        check("events_left", 32'(evq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
